// File: rtl/uart_tx_fifo_if.sv
// Push-side and serial-line signals of the FIFO-fronted UART transmitter.
interface uart_tx_fifo_if #(
  parameter int NB    = 8,
  parameter int DEPTH = 16
);
  logic                   wr_en;
  logic [NB-1:0]          wr_data;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   tx;
  logic                   busy;
  logic                   frame_done;

  modport master (output wr_en, wr_data,
                  input  full, empty, count, overflow, tx, busy, frame_done);
  modport slave  (input  wr_en, wr_data,
                  output full, empty, count, overflow, tx, busy, frame_done);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a DEPTH-entry character FIFO. Frames are
// start / NB data (LSB first) / optional parity / NSTOP stop bits, each bit
// RATIO clocks long. Queued characters go out back to back with no idle bit.
module uart_tx_fifo #(
  parameter int FCLK     = 100_000_000,
  parameter int BAUDRATE = 9600,
  parameter int NB       = 8,
  parameter int PARITY   = 0,
  parameter int NSTOP    = 1,
  parameter int DEPTH    = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);
  localparam int RATIO = FCLK / BAUDRATE;
  localparam int CW    = $clog2(RATIO);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [CW-1:0] RELOAD = CW'(RATIO - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // ---------------- FIFO ----------------
  logic [NB-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt_q;
  logic          push, pop, ovf_q;
  logic [NB-1:0] rd_data;

  assign bus.full     = (cnt_q == (AW+1)'(DEPTH));
  assign bus.empty    = (cnt_q == '0);
  assign bus.count    = cnt_q;
  assign bus.overflow = ovf_q;
  assign push         = bus.wr_en && !bus.full;
  assign rd_data      = mem[rptr];

  // Pointers, occupancy and the overflow pulse; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      ovf_q <= bus.wr_en && bus.full;
    end
  end

  // Storage write; pointers are frozen in reset so a gated write is enough.
  always_ff @(posedge clk) begin
    if (rst && push) mem[wptr] <= bus.wr_data;
  end

  // ---------------- transmitter ----------------
  state_t        state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [3:0]    bcnt, bcnt_n;
  logic [NB-1:0] sr, sr_n;
  logic          par_q, par_n;
  logic          tx_q, tx_n;
  logic          tick, done;

  assign tick           = (baud == '0);
  assign bus.tx         = tx_q;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = done;

  // Transmitter state; tx is a flop loaded with the level of the next clock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      baud  <= '0;
      bcnt  <= '0;
      sr    <= '0;
      par_q <= 1'b0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_n;
      baud  <= baud_n;
      bcnt  <= bcnt_n;
      sr    <= sr_n;
      par_q <= par_n;
      tx_q  <= tx_n;
    end
  end

  // Next-state, baud timing and line level; a pop always starts a new frame.
  always_comb begin
    state_n = state;
    baud_n  = (tick || state == IDLE) ? RELOAD : baud - CW'(1);
    bcnt_n  = bcnt;
    sr_n    = sr;
    par_n   = par_q;
    tx_n    = tx_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        pop  = !bus.empty;
      end
      START: if (tick) begin
        state_n = DATA;
        bcnt_n  = '0;
        tx_n    = sr[0];
      end
      DATA: if (tick) begin
        if (bcnt == 4'(NB - 1)) begin
          bcnt_n = '0;
          if (PARITY != 0) begin
            state_n = PAR;
            tx_n    = par_q;
          end else begin
            state_n = STOP;
            tx_n    = 1'b1;
          end
        end else begin
          bcnt_n = bcnt + 4'd1;
          sr_n   = sr >> 1;
          tx_n   = sr[1];
        end
      end
      PAR: if (tick) begin
        state_n = STOP;
        bcnt_n  = '0;
        tx_n    = 1'b1;
      end
      STOP: if (tick) begin
        if (bcnt == 4'(NSTOP - 1)) begin
          done = 1'b1;
          if (!bus.empty) begin
            pop = 1'b1;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          bcnt_n = bcnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (pop) begin
      state_n = START;
      sr_n    = rd_data;
      par_n   = (PARITY == 1) ? ~(^rd_data) : ^rd_data;
      tx_n    = 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1 depth 4, 8E1, 8O2), a
// negedge recorder of the selected instance and a bit-list line model.
module tb_uart_tx_fifo;
  localparam int RATIO = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] wr_en_r;
  logic [7:0] wr_d [3];
  logic [2:0] tx_w, busy_w, fd_w, ovf_w, full_w, empty_w;
  logic [4:0] cnt_w [3];

  uart_tx_fifo_if #(.NB(8), .DEPTH(4))  if_a ();
  uart_tx_fifo_if #(.NB(8), .DEPTH(16)) if_b ();
  uart_tx_fifo_if #(.NB(8), .DEPTH(16)) if_c ();

  uart_tx_fifo #(.FCLK(100), .BAUDRATE(10), .NB(8), .PARITY(0), .NSTOP(1), .DEPTH(4))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  uart_tx_fifo #(.FCLK(100), .BAUDRATE(10), .NB(8), .PARITY(2), .NSTOP(1), .DEPTH(16))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  uart_tx_fifo #(.FCLK(100), .BAUDRATE(10), .NB(8), .PARITY(1), .NSTOP(2), .DEPTH(16))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.wr_en = wr_en_r[0];  assign if_a.wr_data = wr_d[0];
  assign if_b.wr_en = wr_en_r[1];  assign if_b.wr_data = wr_d[1];
  assign if_c.wr_en = wr_en_r[2];  assign if_c.wr_data = wr_d[2];
  assign tx_w    = {if_c.tx, if_b.tx, if_a.tx};
  assign busy_w  = {if_c.busy, if_b.busy, if_a.busy};
  assign fd_w    = {if_c.frame_done, if_b.frame_done, if_a.frame_done};
  assign ovf_w   = {if_c.overflow, if_b.overflow, if_a.overflow};
  assign full_w  = {if_c.full, if_b.full, if_a.full};
  assign empty_w = {if_c.empty, if_b.empty, if_a.empty};
  assign cnt_w[0] = 5'(if_a.count);
  assign cnt_w[1] = if_b.count;
  assign cnt_w[2] = if_c.count;

  int n_chk = 0;
  int n_fail = 0;

  // recorder: {tx, busy, frame_done, overflow} of instance mon, every negedge
  int         mon = 0;
  logic [3:0] rec [$];
  always @(negedge clk) rec.push_back({tx_w[mon], busy_w[mon], fd_w[mon], ovf_w[mon]});

  logic [7:0] msg [$];
  logic [2:0] exp_q [$];   // {tx, busy, frame_done} per clock

  function automatic int par_of(int idx);
    return (idx == 1) ? 2 : (idx == 2) ? 1 : 0;
  endfunction
  function automatic int nst_of(int idx);
    return (idx == 2) ? 2 : 1;
  endfunction

  // Expected line for msg pushed back to back starting at recorder index 0:
  // two idle samples, then each character's bit list stretched to RATIO clocks.
  function automatic void model(int idx);
    logic bits [$];
    int   flen, n;
    exp_q.delete();
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b100);
    foreach (msg[k]) begin
      bits.delete();
      bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) bits.push_back(msg[k][j]);
      if (par_of(idx) != 0) bits.push_back((^msg[k]) ^ (par_of(idx) == 1));
      for (int s = 0; s < nst_of(idx); s++) bits.push_back(1'b1);
      flen = bits.size() * RATIO;
      n = 0;
      foreach (bits[b])
        for (int r = 0; r < RATIO; r++) begin
          n++;
          exp_q.push_back({bits[b], 1'b1, (n == flen)});
        end
    end
    exp_q.push_back(3'b100);
  endfunction

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(int idx, logic [7:0] d);
    wr_en_r[idx] = 1'b1;
    wr_d[idx]    = d;
    tick(1);
    wr_en_r[idx] = 1'b0;
  endtask

  // stimulus only: record instance idx while msg is pushed and drained
  task automatic send(int idx);
    mon = idx;
    rec.delete();
    foreach (msg[k]) push(idx, msg[k]);
    model(idx);
    tick(exp_q.size());
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wr_en_r = 3'b111;
    for (int i = 0; i < 3; i++) wr_d[i] = 8'h3C;
    tick(2);
    wr_en_r = 3'b000;
    rst = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({tx_w[i], busy_w[i], fd_w[i], ovf_w[i], full_w[i], empty_w[i]} !== 6'b100001) begin
        n_fail++;
        $display("FAIL reset_flags[%0d] got tx/busy/fd/ovf/full/empty=%b want 100001", i,
                 {tx_w[i], busy_w[i], fd_w[i], ovf_w[i], full_w[i], empty_w[i]});
      end
      n_chk++;
      if (cnt_w[i] !== 5'd0) begin
        n_fail++;
        $display("FAIL reset_count[%0d] got %0d want 0", i, cnt_w[i]);
      end
    end
  endtask

  task automatic test_frame_8n1();
    int bad;
    msg = '{8'h55};
    mon = 0;
    rec.delete();
    push(0, 8'h55);
    n_chk++;
    if (cnt_w[0] !== 5'd1 || empty_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL push_visible got count=%0d empty=%b want 1/0", cnt_w[0], empty_w[0]);
    end
    model(0);
    tick(exp_q.size());
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && (i >= rec.size() || rec[i][3:1] !== exp_q[i])) bad = i;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL wave_8n1 at %0d got %b want %b", bad, rec[bad][3:1], exp_q[bad]);
    end
    n_chk++;
    if (rec[101][1] !== 1'b1 || rec[102][3] !== 1'b1) begin
      n_fail++;
      $display("FAIL len_8n1 got fd@101=%b tx@102=%b want 1/1", rec[101][1], rec[102][3]);
    end
  endtask

  task automatic test_parity();
    int bad;
    msg = '{8'h07};
    send(1);
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && (i >= rec.size() || rec[i][3:1] !== exp_q[i])) bad = i;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL wave_even at %0d got %b want %b", bad, rec[bad][3:1], exp_q[bad]);
    end
    n_chk++;
    if (rec[97][3] !== 1'b1 || rec[111][1] !== 1'b1) begin
      n_fail++;
      $display("FAIL even_bit_len got par=%b fd@111=%b want 1/1", rec[97][3], rec[111][1]);
    end
    send(2);
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && (i >= rec.size() || rec[i][3:1] !== exp_q[i])) bad = i;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL wave_odd at %0d got %b want %b", bad, rec[bad][3:1], exp_q[bad]);
    end
    n_chk++;
    if (rec[97][3] !== 1'b0) begin
      n_fail++;
      $display("FAIL odd_bit got %b want 0", rec[97][3]);
    end
  endtask

  task automatic test_nstop2();
    int bad, hi;
    msg = '{8'hFF};
    send(2);
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && (i >= rec.size() || rec[i][3:1] !== exp_q[i])) bad = i;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL wave_2stop at %0d got %b want %b", bad, rec[bad][3:1], exp_q[bad]);
    end
    hi = 0;
    for (int i = 102; i <= 121; i++) hi += int'(rec[i][3]);
    n_chk++;
    if (hi != 20 || rec[121][1] !== 1'b1) begin
      n_fail++;
      $display("FAIL stop2_hold got high=%0d fd=%b want 20/1", hi, rec[121][1]);
    end
  endtask

  task automatic test_back_to_back();
    int bad, nfd, nidle;
    msg = '{8'hA1, 8'hB2, 8'hC3};
    send(0);
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && (i >= rec.size() || rec[i][3:1] !== exp_q[i])) bad = i;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL wave_b2b at %0d got %b want %b", bad, rec[bad][3:1], exp_q[bad]);
    end
    nfd = 0;
    nidle = 0;
    for (int i = 2; i <= 301; i++) begin
      nfd += int'(rec[i][1]);
      nidle += int'(!rec[i][2]);
    end
    n_chk++;
    if (nfd != 3 || nidle != 0 || !(rec[101][1] && rec[201][1] && rec[301][1])) begin
      n_fail++;
      $display("FAIL b2b_spacing got fd=%0d idle=%0d want 3/0 at 101,201,301", nfd, nidle);
    end
  endtask

  task automatic test_overflow();
    int bad, novf;
    msg = '{8'h5A, 8'h11, 8'h22, 8'h33, 8'h44};
    mon = 0;
    rec.delete();
    push(0, msg[0]);
    tick(3);
    for (int k = 1; k <= 4; k++) push(0, msg[k]);
    push(0, 8'hEE);
    n_chk++;
    if (cnt_w[0] !== 5'd4 || full_w[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_state got count=%0d full=%b want 4/1", cnt_w[0], full_w[0]);
    end
    model(0);
    tick(exp_q.size() + 20);
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && (i >= rec.size() || rec[i][3:1] !== exp_q[i])) bad = i;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL wave_ovf at %0d got %b want %b", bad, rec[bad][3:1], exp_q[bad]);
    end
    novf = 0;
    foreach (rec[i]) novf += int'(rec[i][0]);
    n_chk++;
    if (novf != 1 || busy_w[0] !== 1'b0 || cnt_w[0] !== 5'd0) begin
      n_fail++;
      $display("FAIL ovf_pulse got pulses=%0d busy=%b count=%0d want 1/0/0", novf, busy_w[0], cnt_w[0]);
    end
  endtask

  task automatic test_reset_midframe();
    int act;
    logic [7:0] d0;
    d0 = 8'($urandom);
    push(0, d0);
    push(0, 8'($urandom));
    push(0, 8'($urandom));
    tick(44);
    n_chk++;
    if (busy_w[0] !== 1'b1 || cnt_w[0] !== 5'd2 || tx_w[0] !== d0[3]) begin
      n_fail++;
      $display("FAIL pre_reset got busy=%b count=%0d tx=%b want 1/2/%b", busy_w[0], cnt_w[0], tx_w[0], d0[3]);
    end
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    n_chk++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cnt_w[0] !== 5'd0 || empty_w[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort got tx=%b busy=%b count=%0d empty=%b want 1/0/0/1",
               tx_w[0], busy_w[0], cnt_w[0], empty_w[0]);
    end
    mon = 0;
    rec.delete();
    tick(150);
    act = 0;
    foreach (rec[i]) act += int'(rec[i][2] || !rec[i][3]);
    n_chk++;
    if (act != 0) begin
      n_fail++;
      $display("FAIL stay_idle got %0d active clocks want 0", act);
    end
  endtask

  task automatic test_random();
    int bad, idx, n;
    for (int r = 0; r < 6; r++) begin
      idx = r % 3;
      n = $urandom_range(1, 3);
      msg.delete();
      for (int k = 0; k < n; k++) msg.push_back(8'($urandom));
      send(idx);
      bad = -1;
      foreach (exp_q[i]) if (bad < 0 && (i >= rec.size() || rec[i][3:1] !== exp_q[i])) bad = i;
      n_chk++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL wave_rand[%0d] inst %0d at %0d got %b want %b", r, idx, bad, rec[bad][3:1], exp_q[bad]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    wr_en_r = '0;
    for (int i = 0; i < 3; i++) wr_d[i] = '0;
    test_reset();
    test_frame_8n1();
    test_parity();
    test_nstop2();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter FCLK, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUDRATE, default 9600, line bit rate in bit/s; RATIO = FCLK/BAUDRATE (integer division), RATIO >= 2.
REQ-003 Parameter NB, default 8, data bits per frame, legal range 5..9.
REQ-004 Parameter PARITY, default 0; 0 = none, 1 = odd, 2 = even.
REQ-005 Parameter NSTOP, default 1, number of stop bits, legal values 1 or 2.
REQ-006 Parameter DEPTH, default 16, FIFO entries, power of two, >= 2.
REQ-007 clk  input  1  single system clock; all logic on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-low.
REQ-009 wr_en  input  1  push request for wr_data.
REQ-010 wr_data  input  NB  character to queue.
REQ-011 full  output  1  FIFO holds DEPTH entries.
REQ-012 empty  output  1  FIFO holds 0 entries.
REQ-013 count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  output  1  one-cycle pulse on a push attempted while full.
REQ-015 tx  output  1  serial line, idle high, registered.
REQ-016 busy  output  1  high while the FSM is in any state other than IDLE.
REQ-017 frame_done  output  1  one-cycle pulse in the last clock of the final stop bit.

Function
REQ-018 The push accepts only when wr_en=1 and full=0; an accepted push is visible in count on the next cycle.
REQ-019 A push while full shall be dropped, leave FIFO contents and count unchanged, and pulse overflow for one cycle.
REQ-020 A simultaneous accepted push and pop shall leave count unchanged; a push while empty together with no pop increments count by 1.
REQ-021 FIFO read/write pointers shall wrap modulo DEPTH; full = (count == DEPTH), empty = (count == 0).
REQ-022 FSM states: IDLE, START, DATA, PAR, STOP.
REQ-023 IDLE -> START when empty=0; the head entry is popped into a shift register in that same cycle, and tx goes low on the next cycle.
REQ-024 Each bit (start, data, parity, stop) shall hold tx stable for exactly RATIO clocks, timed by a baud counter that reloads at every bit boundary.
REQ-025 START -> DATA after RATIO clocks; DATA sends NB bits LSB first, then goes to PAR if PARITY != 0, else to STOP.
REQ-026 The PAR bit shall equal XOR of the NB data bits for even parity and its complement for odd parity.
REQ-027 STOP drives tx high for NSTOP*RATIO clocks, then pulses frame_done.
REQ-028 At the end of STOP, if empty=0 the FSM shall pop and go directly to START with no idle bit; otherwise it goes to IDLE.
REQ-029 Frame length in clocks shall be (1 + NB + (PARITY!=0) + NSTOP) * RATIO.
REQ-030 The baud counter shall be held at reload value while in IDLE.
REQ-031 Pushes during an active frame shall not disturb the frame in flight.

Reset
REQ-032 While rst=0 at a rising clk: FSM -> IDLE, tx=1, busy=0, frame_done=0, overflow=0, count=0, empty=1, full=0, pointers and baud counter cleared.
REQ-033 A reset asserted mid-frame shall abort the frame, drive tx=1 on the following cycle, and discard all queued data.
REQ-034 A push presented in a cycle with rst=0 shall be ignored.

Verification
REQ-035 FCLK=100, BAUDRATE=10 (RATIO=10), 8N1: push 0x55 -> tx low for 10 clocks starting 1 cycle after the push is visible, then bits 1,0,1,0,1,0,1,0 for 10 clocks each, high 10 clocks, frame_done once, total frame 100 clocks.
REQ-036 PARITY=2, NB=8: push 0x07 -> parity bit 1; PARITY=1: push 0x07 -> parity bit 0; frame length 110 clocks.
REQ-037 DEPTH=4: 5 pushes back-to-back with transmitter stalled by keeping a frame in flight -> count 4, full=1, overflow pulses exactly once, the 5th byte is never transmitted.
REQ-038 Push 0xA1, 0xB2, 0xC3 -> three frames contiguous with no extra idle clocks, busy high continuously, three frame_done pulses spaced 100 clocks apart.
REQ-039 NSTOP=2: push 0xFF -> stop level held 20 clocks before frame_done.
REQ-040 rst=0 for one cycle during data bit 3 with 2 entries queued -> tx=1, busy=0, count=0 next cycle; no further frame starts until a new push.
